// File: rtl/dtb_host_bridge.sv
// Host byte-stream command bridge in front of the stream trace buffer: decodes
// opcodes into control/data-write/read transactions and serialises read words back.
// Optional macro DTB_BRIDGE_ACK_EN: ACK (0x06) after each write, NAK (0x15) on unknown opcodes.
module dtb_host_bridge #(
    parameter int unsigned TRB_WIDTH  = 32,
    parameter int unsigned CONF_WIDTH = 16,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  RX_VALID_I,
    output logic                  RX_READY_O,
    input  logic [7:0]            RX_DATA_I,
    output logic                  TX_VALID_O,
    input  logic                  TX_READY_I,
    output logic [7:0]            TX_DATA_O,
    output logic                  CTRL_VALID_O,
    input  logic                  CTRL_READY_I,
    output logic [CONF_WIDTH-1:0] CTRL_O,
    output logic                  STAT_READY_O,
    input  logic                  STAT_VALID_I,
    input  logic [STAT_WIDTH-1:0] STAT_I,
    output logic                  WDATA_VALID_O,
    input  logic                  WDATA_READY_I,
    output logic [TRB_WIDTH-1:0]  WDATA_O,
    output logic                  RDATA_READY_O,
    input  logic                  RDATA_VALID_I,
    input  logic [TRB_WIDTH-1:0]  RDATA_I
);
    localparam int unsigned NB_CONF = (CONF_WIDTH + 7) / 8;
    localparam int unsigned NB_STAT = (STAT_WIDTH + 7) / 8;
    localparam int unsigned NB_DATA = TRB_WIDTH / 8;
    localparam int unsigned NB_CS   = (NB_CONF > NB_STAT) ? NB_CONF : NB_STAT;
    localparam int unsigned NB_MAX  = (NB_CS > NB_DATA) ? NB_CS : NB_DATA;
    localparam int unsigned CW      = $clog2(NB_MAX + 1);
    localparam int unsigned SW      = NB_MAX * 8;

    localparam logic [CW-1:0] LAST_CONF = CW'(NB_CONF - 1);
    localparam logic [CW-1:0] LAST_STAT = CW'(NB_STAT - 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(NB_DATA - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_ARG, S_ISSUE, S_WAIT_RD, S_TX, S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] shadow_q, shadow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_data_q, is_data_d;
    logic          nak_q, nak_d;

    logic       rx_ready, tx_valid, ctrl_valid, wdata_valid, stat_ready, rdata_ready;
    logic [7:0] tx_byte;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            cnt_q     <= '0;
            is_data_q <= 1'b0;
            nak_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            is_data_q <= is_data_d;
            nak_q     <= nak_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        is_data_d   = is_data_q;
        nak_d       = nak_q;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        tx_byte     = '0;
        ctrl_valid  = 1'b0;
        wdata_valid = 1'b0;
        stat_ready  = 1'b0;
        rdata_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (RX_VALID_I) begin
                    case (RX_DATA_I)
                        8'h01, 8'h03: begin
                            is_data_d = RX_DATA_I[1];
                            cnt_d     = '0;
                            state_d   = S_RX_ARG;
                        end
                        8'h02, 8'h04: begin
                            is_data_d = RX_DATA_I[2];
                            state_d   = S_WAIT_RD;
                        end
                        default: begin
`ifdef DTB_BRIDGE_ACK_EN
                            nak_d   = 1'b1;
                            state_d = S_ACK;
`endif
                        end
                    endcase
                end
            end
            S_RX_ARG: begin
                rx_ready = 1'b1;
                if (RX_VALID_I) begin
                    shadow_d[8*int'(cnt_q) +: 8] = RX_DATA_I;
                    if (cnt_q == (is_data_q ? LAST_DATA : LAST_CONF)) begin
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                ctrl_valid  = !is_data_q;
                wdata_valid = is_data_q;
                if (is_data_q ? WDATA_READY_I : CTRL_READY_I) begin
`ifdef DTB_BRIDGE_ACK_EN
                    nak_d   = 1'b0;
                    state_d = S_ACK;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_WAIT_RD: begin
                stat_ready  = !is_data_q;
                rdata_ready = is_data_q;
                if (is_data_q ? RDATA_VALID_I : STAT_VALID_I) begin
                    // Zero-fill first so status bits above STAT_WIDTH go out as 0.
                    shadow_d = '0;
                    if (is_data_q) shadow_d[TRB_WIDTH-1:0] = RDATA_I;
                    else           shadow_d[STAT_WIDTH-1:0] = STAT_I;
                    cnt_d   = '0;
                    state_d = S_TX;
                end
            end
            S_TX: begin
                tx_valid = 1'b1;
                tx_byte  = shadow_q[8*int'(cnt_q) +: 8];
                if (TX_READY_I) begin
                    if (cnt_q == (is_data_q ? LAST_DATA : LAST_STAT)) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ACK: begin
                tx_valid = 1'b1;
                tx_byte  = nak_q ? 8'h15 : 8'h06;
                if (TX_READY_I) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are masked during reset so a same-edge handshake cannot occur.
    assign RX_READY_O    = rx_ready    & ~RST_I;
    assign TX_VALID_O    = tx_valid    & ~RST_I;
    assign TX_DATA_O     = RST_I ? '0 : tx_byte;
    assign CTRL_VALID_O  = ctrl_valid  & ~RST_I;
    assign WDATA_VALID_O = wdata_valid & ~RST_I;
    assign STAT_READY_O  = stat_ready  & ~RST_I;
    assign RDATA_READY_O = rdata_ready & ~RST_I;
    assign CTRL_O        = shadow_q[CONF_WIDTH-1:0];
    assign WDATA_O       = shadow_q[TRB_WIDTH-1:0];

endmodule

// File: tb/tb_dtb_host_bridge.sv
// Scoreboard bench for dtb_host_bridge: directed plan cases plus random command mix,
// expected bytes/words computed from the command semantics and queued for a monitor.
module tb_dtb_host_bridge;
    localparam int unsigned TRB_W  = 32;
    localparam int unsigned CONF_W = 16;
    localparam int unsigned STAT_W = 12;
    localparam int unsigned NB_C   = (CONF_W + 7) / 8;
    localparam int unsigned NB_S   = (STAT_W + 7) / 8;
    localparam int unsigned NB_D   = TRB_W / 8;

    logic              clk = 1'b0;
    logic              RST_I, RX_VALID_I, RX_READY_O, TX_VALID_O, TX_READY_I;
    logic [7:0]        RX_DATA_I, TX_DATA_O;
    logic              CTRL_VALID_O, CTRL_READY_I, STAT_READY_O, STAT_VALID_I;
    logic              WDATA_VALID_O, WDATA_READY_I, RDATA_READY_O, RDATA_VALID_I;
    logic [CONF_W-1:0] CTRL_O;
    logic [STAT_W-1:0] STAT_I;
    logic [TRB_W-1:0]  WDATA_O, RDATA_I;

    always #5 clk = ~clk;

    dtb_host_bridge #(.TRB_WIDTH(TRB_W), .CONF_WIDTH(CONF_W), .STAT_WIDTH(STAT_W)) dut (
        .CLK_I(clk), .RST_I(RST_I),
        .RX_VALID_I(RX_VALID_I), .RX_READY_O(RX_READY_O), .RX_DATA_I(RX_DATA_I),
        .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I), .TX_DATA_O(TX_DATA_O),
        .CTRL_VALID_O(CTRL_VALID_O), .CTRL_READY_I(CTRL_READY_I), .CTRL_O(CTRL_O),
        .STAT_READY_O(STAT_READY_O), .STAT_VALID_I(STAT_VALID_I), .STAT_I(STAT_I),
        .WDATA_VALID_O(WDATA_VALID_O), .WDATA_READY_I(WDATA_READY_I), .WDATA_O(WDATA_O),
        .RDATA_READY_O(RDATA_READY_O), .RDATA_VALID_I(RDATA_VALID_I), .RDATA_I(RDATA_I)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0]        exp_tx[$];
    logic [CONF_W-1:0] exp_ctrl[$];
    logic [TRB_W-1:0]  exp_wdata[$];
    logic [STAT_W-1:0] stat_vals[$];
    logic [TRB_W-1:0]  rdata_vals[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] got);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%0h expected no transfer at %0t", name, got, $time);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rx_ready", RX_READY_O, 0);
        chk("rst_tx_valid", TX_VALID_O, 0);
        chk("rst_tx_data", TX_DATA_O, 0);
        chk("rst_ctrl_valid", CTRL_VALID_O, 0);
        chk("rst_ctrl", CTRL_O, 0);
        chk("rst_wdata_valid", WDATA_VALID_O, 0);
        chk("rst_wdata", WDATA_O, 0);
        chk("rst_stat_ready", STAT_READY_O, 0);
        chk("rst_rdata_ready", RDATA_READY_O, 0);
    endtask

    // Random ready pressure on host TX and the buffer write ports.
    initial begin
        TX_READY_I = 0; CTRL_READY_I = 0; WDATA_READY_I = 0;
        forever begin
            @(posedge clk); #1;
            TX_READY_I    = ($urandom_range(0, 1) == 1);
            CTRL_READY_I  = ($urandom_range(0, 3) == 0);
            WDATA_READY_I = ($urandom_range(0, 3) == 0);
        end
    end

    // Status responder: answers a pending STAT_READY_O after a random delay.
    initial begin
        STAT_VALID_I = 0; STAT_I = '0;
        forever begin
            @(posedge clk); #1;
            if (!RST_I && STAT_READY_O && stat_vals.size() > 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                STAT_VALID_I = 1; STAT_I = stat_vals.pop_front();
                @(posedge clk); #1;
                STAT_VALID_I = 0;
                chk("stat_to_tx_latency", TX_VALID_O, 1);
            end
        end
    end

    initial begin
        RDATA_VALID_I = 0; RDATA_I = '0;
        forever begin
            @(posedge clk); #1;
            if (!RST_I && RDATA_READY_O && rdata_vals.size() > 0) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                RDATA_VALID_I = 1; RDATA_I = rdata_vals.pop_front();
                @(posedge clk); #1;
                RDATA_VALID_I = 0;
                chk("rdata_to_tx_latency", TX_VALID_O, 1);
            end
        end
    end

    // Monitor: samples on the falling edge, between driver updates and the active edge.
    initial begin
        logic pc_v = 0, pc_r = 0, pw_v = 0, pw_r = 0, pt_v = 0, pt_r = 0;
        logic [CONF_W-1:0] pc_d = '0;
        logic [TRB_W-1:0]  pw_d = '0;
        logic [7:0]        pt_d = '0;
        forever begin
            @(negedge clk);
            if (RST_I) begin
                pc_v = 0; pw_v = 0; pt_v = 0;
            end else begin
                if (pc_v && !pc_r) begin
                    chk("ctrl_hold_valid", CTRL_VALID_O, 1);
                    chk("ctrl_hold_data", CTRL_O, pc_d);
                end
                if (pw_v && !pw_r) begin
                    chk("wdata_hold_valid", WDATA_VALID_O, 1);
                    chk("wdata_hold_data", WDATA_O, pw_d);
                end
                if (pt_v && !pt_r) begin
                    chk("tx_hold_valid", TX_VALID_O, 1);
                    chk("tx_hold_data", TX_DATA_O, pt_d);
                end
                chk("buffer_side_onehot",
                    $countones({CTRL_VALID_O, WDATA_VALID_O, STAT_READY_O, RDATA_READY_O}) <= 1, 1);
                chk("rx_ready_exclusive", RX_READY_O &&
                    (TX_VALID_O || CTRL_VALID_O || WDATA_VALID_O || STAT_READY_O || RDATA_READY_O), 0);
                if (CTRL_VALID_O && CTRL_READY_I) begin
                    if (exp_ctrl.size() == 0) unexpected("ctrl_unexpected", CTRL_O);
                    else chk("ctrl_word", CTRL_O, exp_ctrl.pop_front());
                end
                if (WDATA_VALID_O && WDATA_READY_I) begin
                    if (exp_wdata.size() == 0) unexpected("wdata_unexpected", WDATA_O);
                    else chk("wdata_word", WDATA_O, exp_wdata.pop_front());
                end
                if (TX_VALID_O && TX_READY_I) begin
                    if (exp_tx.size() == 0) unexpected("tx_unexpected", TX_DATA_O);
                    else chk("tx_byte", TX_DATA_O, exp_tx.pop_front());
                end
                pc_v = CTRL_VALID_O;  pc_r = CTRL_READY_I;  pc_d = CTRL_O;
                pw_v = WDATA_VALID_O; pw_r = WDATA_READY_I; pw_d = WDATA_O;
                pt_v = TX_VALID_O;    pt_r = TX_READY_I;    pt_d = TX_DATA_O;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        RX_VALID_I = 1; RX_DATA_I = b;
        @(negedge clk);
        while (!RX_READY_O && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) unexpected("rx_accept_timeout", b);
        @(posedge clk); #1;
        RX_VALID_I = 0;
    endtask

    task automatic wr_conf(input logic [CONF_W-1:0] w);
        exp_ctrl.push_back(w);
`ifdef DTB_BRIDGE_ACK_EN
        exp_tx.push_back(8'h06);
`endif
        send_byte(8'h01);
        for (int i = 0; i < int'(NB_C); i++) send_byte(8'((w >> (8 * i)) & 'hFF));
        chk("wr_conf_latency", CTRL_VALID_O, 1);
    endtask

    task automatic wr_data(input logic [TRB_W-1:0] w);
        exp_wdata.push_back(w);
`ifdef DTB_BRIDGE_ACK_EN
        exp_tx.push_back(8'h06);
`endif
        send_byte(8'h03);
        for (int i = 0; i < int'(NB_D); i++) send_byte(8'((w >> (8 * i)) & 'hFF));
        chk("wr_data_latency", WDATA_VALID_O, 1);
    endtask

    task automatic rd_stat(input logic [STAT_W-1:0] s);
        stat_vals.push_back(s);
        for (int i = 0; i < int'(NB_S); i++) exp_tx.push_back(8'((32'(s) >> (8 * i)) & 'hFF));
        send_byte(8'h02);
        chk("rd_stat_latency", STAT_READY_O, 1);
    endtask

    task automatic rd_data(input logic [TRB_W-1:0] d);
        rdata_vals.push_back(d);
        for (int i = 0; i < int'(NB_D); i++) exp_tx.push_back(8'((d >> (8 * i)) & 'hFF));
        send_byte(8'h04);
        chk("rd_data_latency", RDATA_READY_O, 1);
    endtask

    task automatic bad_op(input logic [7:0] op);
`ifdef DTB_BRIDGE_ACK_EN
        exp_tx.push_back(8'h15);
`endif
        send_byte(op);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST_I = 1; RX_VALID_I = 0; RX_DATA_I = '0;
        repeat (3) begin
            @(posedge clk); #1;
            chk_reset_outputs();
        end
        RST_I = 0;
        #1;
        chk("rx_ready_after_reset", RX_READY_O, 1);

        // Directed cases from the test plan.
        wr_conf(16'h1234);
        rd_data(32'hDEADBEEF);
        rd_stat(12'hABC);

        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        RST_I = 1;
        @(posedge clk); #1;
        chk_reset_outputs();
        RST_I = 0;
        #1;
        chk("rx_ready_after_mid_reset", RX_READY_O, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no_wdata_after_reset", WDATA_VALID_O, 0);
        end
        wr_data(32'h04030201);

        bad_op(8'h7F);
        rd_stat(12'h5A3);

        // Random command mix.
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 4))
                0: wr_conf(CONF_W'($urandom));
                1: rd_stat(STAT_W'($urandom));
                2: wr_data($urandom);
                3: rd_data($urandom);
                default: bad_op(8'($urandom_range(5, 255)));
            endcase
        end

        n = 0;
        while ((exp_tx.size() + exp_ctrl.size() + exp_wdata.size() +
                stat_vals.size() + rdata_vals.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", exp_tx.size() + exp_ctrl.size() + exp_wdata.size() +
            stat_vals.size() + rdata_vals.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("final_idle_rx_ready", RX_READY_O, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dtb_host_bridge.md
# dtb_host_bridge

Byte-oriented host command bridge that sits directly upstream of the stream trace buffer on the system side. It decodes a byte stream, typically from a UART receiver, into ready/valid transactions on the buffer's control, status, data-write and data-read ports. It serialises status and data words back into a byte stream for the host. All buffer-side words are assembled and emitted LSB-byte first.

## Interface
- TRB_WIDTH, 32: data word width in bits; must be a multiple of 8.
- CONF_WIDTH, 16: control word width in bits (any value ≥1).
- STAT_WIDTH, 16: status word width in bits (any value ≥1).
- Derived values:
  - NB_CONF = ceil(CONF_WIDTH/8).
  - NB_STAT = ceil(STAT_WIDTH/8).
  - NB_DATA = TRB_WIDTH/8.
- CLK_I  in  1  single clock; all logic is on the rising edge.
- RST_I  in  1  synchronous, active-high reset.
- RX_VALID_I / RX_READY_O / RX_DATA_I[7:0]  in/out/in: host byte input.
- TX_VALID_O / TX_READY_I / TX_DATA_O[7:0]  out/in/out: host byte output.
- CTRL_VALID_O / CTRL_READY_I / CTRL_O[CONF_WIDTH]  out/in/out: to the buffer's control port.
- STAT_READY_O / STAT_VALID_I / STAT_I[STAT_WIDTH]  out/in/in: from the buffer's status port.
- WDATA_VALID_O / WDATA_READY_I / WDATA_O[TRB_WIDTH]  out/in/out: to the buffer's data input.
- RDATA_READY_O / RDATA_VALID_I / RDATA_I[TRB_WIDTH]  out/in/in: from the buffer's data output.

## Operation
- Opcodes (first byte of a command):
  - 0x01 WR_CONF: followed by NB_CONF argument bytes.
  - 0x02 RD_STAT: no argument bytes.
  - 0x03 WR_DATA: followed by NB_DATA argument bytes.
  - 0x04 RD_DATA: no argument bytes.
- FSM states:
  - IDLE: RX_READY_O=1. A valid byte is latched as the opcode.
    - 0x01 or 0x03 → RX_ARG, byte counter cleared.
    - 0x02 or 0x04 → WAIT_RD.
    - Any other value → IDLE (byte dropped; see Configuration).
  - RX_ARG: RX_READY_O=1. Each accepted byte is shifted into the shadow register at byte index = counter, and the counter increments. On the last byte → ISSUE.
  - ISSUE: CTRL_VALID_O (WR_CONF) or WDATA_VALID_O (WR_DATA) is held high with a stable word until the matching READY; then → IDLE (or ACK when the macro is defined).
  - WAIT_RD: STAT_READY_O or RDATA_READY_O is held high until the matching VALID. The word is captured into the shadow register, counter cleared → TX.
  - TX: TX_VALID_O=1, TX_DATA_O = shadow byte[counter]. On each TX handshake the counter increments. After byte NB_STAT-1 or NB_DATA-1 → IDLE.
- Width rules:
  - WR_CONF: bits of the last argument byte beyond CONF_WIDTH are discarded.
  - RD_STAT: bits above STAT_WIDTH are sent as zero.
  - The counter is clog2(max(NB_CONF, NB_STAT, NB_DATA)+1) bits wide.
- RX_READY_O=0 in ISSUE, WAIT_RD, TX and ACK. Commands are strictly serial with no pipelining across commands.
- At most one buffer-side VALID or READY output is high in any cycle.

## Timing
- Reset values: all *_VALID_O, *_READY_O (including RX_READY_O) are 0 on the reset cycle; TX_DATA_O, CTRL_O and WDATA_O are 0; FSM is in IDLE; counter is 0.
- RX_READY_O is 1 from the first cycle after reset is released.
- Write latency: a word's last byte accepted in cycle N gives CTRL_VALID_O/WDATA_VALID_O = 1 in cycle N+1.
- Read latency: an opcode accepted in cycle N gives STAT_READY_O/RDATA_READY_O = 1 in cycle N+1. VALID seen in cycle M gives TX_VALID_O = 1 in cycle M+1.
- Back-to-back host bytes are accepted at one per cycle in IDLE and RX_ARG.
- A single-byte TX takes one cycle per byte when TX_READY_I is held high.
- VALID outputs never drop without a handshake, and their data stays stable while VALID is high and READY is low.
- Reset asserted mid-command: the next cycle is IDLE with outputs at their reset values. The partial word is discarded and no transaction completes after reset.
- Handshake on the same edge as reset: ignored.

## Configuration
- Macro DTB_BRIDGE_ACK_EN.
- Defined:
  - After a completed ISSUE, the bridge enters state ACK and sends byte 0x06 on TX before returning to IDLE.
  - An unknown opcode enters ACK and sends 0x15 (NAK).
- Not defined:
  - Writes return to IDLE directly after the handshake with no TX traffic.
  - Unknown opcodes are silently dropped and the bridge stays in IDLE.

## Test plan
- WR_CONF with CONF_WIDTH=16: bytes 0x01,0x34,0x12 → CTRL_O=0x1234 with CTRL_VALID_O one cycle after the 0x12 byte. CTRL_READY_I is stalled 5 cycles; the word must hold stable.
- RD_DATA with TRB_WIDTH=32: byte 0x04, then RDATA_I=0xDEADBEEF asserted valid 3 cycles later → TX bytes 0xEF,0xBE,0xAD,0xDE in order. TX_READY_I toggles every other cycle.
- RD_STAT with STAT_WIDTH=12: STAT_I=0xABC → TX bytes 0xBC,0x0A.
- Reset mid-WR_DATA: bytes 0x03,0x11,0x22, then RST_I for 1 cycle → no WDATA_VALID_O. A following full WR_DATA 0x03,0x01,0x02,0x03,0x04 yields WDATA_O=0x04030201.
- Unknown opcode 0x7F followed by RD_STAT:
  - With DTB_BRIDGE_ACK_EN: TX 0x15, then the status bytes.
  - Without DTB_BRIDGE_ACK_EN: only the status bytes.
- WR_CONF with DTB_BRIDGE_ACK_EN defined → a single TX byte 0x06 after the CTRL handshake, and RX_READY_O stays 0 until that byte is accepted.
